net2axis_master: RTL and testbench

NET2AXIS_MASTER -- requirements
Module: net2axis_master

---
 rtl/net2axis_master.sv | 116 +++++++++++
 tb/tb_net2axis_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/net2axis_master.sv
// AXI4-Stream packet generator: after START, emits C_NUM_PKTS packets of
// C_PKT_BYTES bytes each, with C_DELAY idle cycles before every packet.
module net2axis_master #(
  parameter int unsigned C_TDATA_WIDTH = 32,
  parameter int unsigned C_PKT_BYTES   = 10,
  parameter int unsigned C_NUM_PKTS    = 4,
  parameter int unsigned C_DELAY       = 10
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         START,
  output logic                         M_AXIS_TVALID,
  output logic [C_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_TDATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
  output logic                         M_AXIS_TLAST,
  input  logic                         M_AXIS_TREADY,
  output logic                         BUSY,
  output logic                         DONE
);

  localparam int unsigned BPB    = C_TDATA_WIDTH / 8;
  localparam int unsigned NB     = (C_PKT_BYTES + BPB - 1) / BPB;
  localparam int unsigned REM    = C_PKT_BYTES % BPB;
  localparam bit          NO_DLY = (C_DELAY == 0);

  localparam logic [BPB-1:0] KEEP_ALL  = '1;
  localparam logic [BPB-1:0] KEEP_LAST = (REM == 0) ? KEEP_ALL : (KEEP_ALL >> (BPB - REM));
  localparam logic [15:0]    BEAT_LAST = 16'(NB - 1);
  localparam logic [15:0]    DLY_LAST  = 16'(C_DELAY - 1);
  localparam logic [15:0]    PKT_LAST  = 16'(C_NUM_PKTS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_SEND,
    S_FINISH
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [15:0]    r_pkt_id;
  logic [15:0]    r_beat;
  logic [15:0]    r_delay_cnt;
  logic           w_handshake;
  logic           w_last_beat;
  logic           w_last_pkt;
  logic           w_delay_done;
  logic [BPB-1:0] w_keep;

  // TVALID is a pure function of state, so the handshake never loops back into TVALID.
  assign w_handshake  = (r_state == S_SEND) && M_AXIS_TREADY;
  assign w_last_beat  = (r_beat == BEAT_LAST);
  assign w_last_pkt   = (r_pkt_id == PKT_LAST);
  assign w_delay_done = (r_delay_cnt == DLY_LAST);
  assign w_keep       = w_last_beat ? KEEP_LAST : KEEP_ALL;

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (START)        w_state_next = NO_DLY ? S_SEND : S_DELAY;
      S_DELAY:  if (w_delay_done) w_state_next = S_SEND;
      S_SEND: begin
        if (w_handshake && w_last_beat) begin
          if (w_last_pkt) w_state_next = S_FINISH;
          else            w_state_next = NO_DLY ? S_SEND : S_DELAY;
        end
      end
      S_FINISH: w_state_next = S_FINISH;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TKEEP  = '0;
    M_AXIS_TDATA  = '0;
    BUSY          = 1'b0;
    DONE          = 1'b0;
    case (r_state)
      S_DELAY: BUSY = 1'b1;
      S_SEND: begin
        BUSY          = 1'b1;
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TLAST  = w_last_beat;
        M_AXIS_TKEEP  = w_keep;
        for (int unsigned i = 0; i < BPB; i++) begin
          if (w_keep[i])
            M_AXIS_TDATA[i*8 +: 8] = 8'(r_pkt_id[7:0] + 8'(32'(r_beat) * BPB + i));
        end
      end
      S_FINISH: DONE = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_pkt_id    <= 16'd1;
      r_beat      <= '0;
      r_delay_cnt <= '0;
    end else begin
      r_delay_cnt <= (r_state == S_DELAY && !w_delay_done) ? r_delay_cnt + 16'd1 : '0;
      if (w_handshake) begin
        r_beat <= w_last_beat ? '0 : r_beat + 16'd1;
        if (w_last_beat) r_pkt_id <= r_pkt_id + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_net2axis_master.sv
// Bench for net2axis_master: a cycle table for the default run plus a
// scoreboard-driven run with random backpressure and a zero-delay variant.
module tb_net2axis_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset, start, tready, sel;
  logic        a_valid, a_last, a_busy, a_done;
  logic [31:0] a_data;
  logic [3:0]  a_keep;
  logic        b_valid, b_last, b_busy, b_done;
  logic [31:0] b_data;
  logic [3:0]  b_keep;
  logic        obs_valid, obs_last, obs_busy, obs_done;
  logic [31:0] obs_data;
  logic [3:0]  obs_keep;

  int total = 0;
  int bad   = 0;

  net2axis_master #(.C_TDATA_WIDTH(32), .C_PKT_BYTES(10), .C_NUM_PKTS(2), .C_DELAY(3)) u_a (
    .ACLK(clk), .ARESET(areset), .START(start),
    .M_AXIS_TVALID(a_valid), .M_AXIS_TDATA(a_data), .M_AXIS_TKEEP(a_keep),
    .M_AXIS_TLAST(a_last), .M_AXIS_TREADY(tready), .BUSY(a_busy), .DONE(a_done));

  net2axis_master #(.C_TDATA_WIDTH(32), .C_PKT_BYTES(8), .C_NUM_PKTS(2), .C_DELAY(0)) u_b (
    .ACLK(clk), .ARESET(areset), .START(start),
    .M_AXIS_TVALID(b_valid), .M_AXIS_TDATA(b_data), .M_AXIS_TKEEP(b_keep),
    .M_AXIS_TLAST(b_last), .M_AXIS_TREADY(tready), .BUSY(b_busy), .DONE(b_done));

  always_comb begin
    obs_valid = sel ? b_valid : a_valid;
    obs_last  = sel ? b_last  : a_last;
    obs_busy  = sel ? b_busy  : a_busy;
    obs_done  = sel ? b_done  : a_done;
    obs_data  = sel ? b_data  : a_data;
    obs_keep  = sel ? b_keep  : a_keep;
  end

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic        start;
    logic        tready;
    logic        valid;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        busy;
    logic        done;
  } vec_t;

  beat_t sb_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] obs_pack();
    return {obs_valid, obs_last, obs_busy, obs_done, obs_keep, obs_data};
  endfunction

  function automatic vec_t mk(input logic st, input logic rdy, input logic v, input logic [31:0] d,
                              input logic [3:0] k, input logic l, input logic b, input logic dn);
    vec_t r;
    r.start = st; r.tready = rdy; r.valid = v; r.data = d;
    r.keep = k; r.last = l; r.busy = b; r.done = dn;
    return r;
  endfunction

  // Expected beats straight from the byte definition: byte k of packet p is (p+k) mod 256.
  task automatic push_run(input int bytes, input int npkts);
    beat_t e;
    int nb, k;
    for (int p = 1; p <= npkts; p++) begin
      nb = (bytes + 3) / 4;
      for (int b = 0; b < nb; b++) begin
        e.data = '0;
        e.keep = '0;
        for (int lane = 0; lane < 4; lane++) begin
          k = b * 4 + lane;
          if (k < bytes) begin
            e.data[lane*8 +: 8] = 8'((p + k) % 256);
            e.keep[lane] = 1'b1;
          end
        end
        e.last = (b == nb - 1);
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic sb_run(input bit rnd, input bit cont, input int bytes);
    int          cyc;
    bit          stall;
    bit          streaming;
    logic [39:0] prev;
    beat_t       e;
    sb_q.delete();
    push_run(bytes, 2);
    start = 1'b1; tready = 1'b0;
    tick();
    start = 1'b0;
    cyc = 0; stall = 1'b0; streaming = 1'b0; prev = '0;
    while (sb_q.size() > 0 && cyc < 400) begin
      if (stall) chk("stall_hold", obs_pack(), prev);
      if (cont && streaming) chk("no_gap", obs_valid, 1);
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (obs_valid && tready) begin
        e = sb_q.pop_front();
        chk("beat", {obs_last, obs_keep, obs_data}, {e.last, e.keep, e.data});
        streaming = 1'b1;
      end
      stall = obs_valid && !tready;
      prev  = obs_pack();
      tick();
      cyc++;
    end
    chk("drained", sb_q.size(), 0);
    chk("done_rise", {obs_done, obs_busy, obs_valid}, 3'b100);
    for (int i = 0; i < 4; i++) begin
      start  = (i == 1);
      tready = 1'b1;
      tick();
      chk("after_done", {obs_done, obs_busy, obs_valid}, 3'b100);
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[15];
    int   w;
    sel = 1'b0; areset = 1'b1; start = 1'b0; tready = 1'b0;
    tick(); tick();
    chk("reset_a", obs_pack(), 40'd0);
    sel = 1'b1; #1;
    chk("reset_b", obs_pack(), 40'd0);
    sel = 1'b0; #1;
    areset = 1'b0;

    tbl[0]  = mk(1, 1, 0, 32'h0,        4'h0, 0, 1, 0);
    tbl[1]  = mk(0, 1, 0, 32'h0,        4'h0, 0, 1, 0);
    tbl[2]  = mk(0, 1, 0, 32'h0,        4'h0, 0, 1, 0);
    tbl[3]  = mk(0, 1, 1, 32'h04030201, 4'hF, 0, 1, 0);
    tbl[4]  = mk(1, 1, 1, 32'h08070605, 4'hF, 0, 1, 0);
    tbl[5]  = mk(0, 1, 1, 32'h00000A09, 4'h3, 1, 1, 0);
    tbl[6]  = mk(0, 1, 0, 32'h0,        4'h0, 0, 1, 0);
    tbl[7]  = mk(0, 1, 0, 32'h0,        4'h0, 0, 1, 0);
    tbl[8]  = mk(0, 1, 0, 32'h0,        4'h0, 0, 1, 0);
    tbl[9]  = mk(0, 1, 1, 32'h05040302, 4'hF, 0, 1, 0);
    tbl[10] = mk(0, 1, 1, 32'h09080706, 4'hF, 0, 1, 0);
    tbl[11] = mk(0, 1, 1, 32'h00000B0A, 4'h3, 1, 1, 0);
    tbl[12] = mk(0, 1, 0, 32'h0,        4'h0, 0, 0, 1);
    tbl[13] = mk(1, 1, 0, 32'h0,        4'h0, 0, 0, 1);
    tbl[14] = mk(0, 1, 0, 32'h0,        4'h0, 0, 0, 1);
    for (int i = 0; i < 15; i++) begin
      start  = tbl[i].start;
      tready = tbl[i].tready;
      tick();
      chk($sformatf("vec%0d", i), obs_pack(),
          {tbl[i].valid, tbl[i].last, tbl[i].busy, tbl[i].done, tbl[i].keep, tbl[i].data});
    end

    areset = 1'b1; start = 1'b1; tready = 1'b1;
    tick();
    chk("reset_from_finish", obs_pack(), 40'd0);
    areset = 1'b0; start = 1'b0;
    tick();
    chk("idle_after_reset", obs_pack(), 40'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!obs_valid && w < 20) begin
      tick();
      w++;
    end
    chk("first_beat", {obs_valid, obs_data}, {1'b1, 32'h04030201});
    tick();
    chk("second_beat", {obs_valid, obs_data}, {1'b1, 32'h08070605});
    areset = 1'b1; start = 1'b1;
    tick();
    chk("abort", obs_pack(), 40'd0);
    areset = 1'b0; start = 1'b0;
    tick();
    chk("abort_idle", obs_pack(), 40'd0);

    sb_run(1'b1, 1'b0, 10);

    areset = 1'b1;
    tick();
    areset = 1'b0;
    sel = 1'b1;
    sb_run(1'b0, 1'b1, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
